pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Merges the combinational hazard stall, branch redirect, multi-cycle divide,
//  I-/D-cache wait and MEM-stage exception into per-stage write-enables and flushes.
//  Sits beside the hazard detector. Its outputs drive the PC and pipeline registers directly.
// PARAMETERS
//  DIV_CYCLES   33   EX occupancy of one divide, in cycles (>=2)
//  MEM_TIMEOUT  255  wait cycles in a cache-wait state before mem_timeout sets
//  PERF_W       32   width of each stall performance counter
// PORTS
//  clk            in   1       pipeline clock
//  rstn           in   1       asynchronous active-low reset
//  hazard_stall   in   1       load-use/compare stall from hazard detector
//  pcsel          in   PcSel   next-PC select from ID (PC_BRANCH = taken redirect)
//  div_start_ex   in   1       divide instruction valid in EX
//  icache_req     in   1       IF fetch outstanding
//  icache_ready   in   1       fetch data valid this cycle
//  dcache_req_mem in   1       MEM load/store outstanding
//  dcache_ready   in   1       D-side response this cycle
//  excp_mem       in   1       exception on MEM-stage instruction
//  pcWriteEn      out  1       PC register update enable
//  IDWriteEn/EXWriteEn/MEMWriteEn  out 1 each  stage register enables
//  IDFlush/EXFlush/MEMFlush/WBFlush out 1 each  insert bubble into stage
//  div_done       out  1       one-cycle pulse: divide result valid in EX
//  mem_timeout    out  1       sticky cache-wait timeout flag
//  stall_state    out  StallState  current FSM state (debug)
// BEHAVIOUR
//  - Reset (rstn low, async): state=ST_RUN; div counter, wait counter, fetch_discard and mem_timeout = 0.
//    While rstn is low, all WriteEn=0 and all Flush=1.
//  - Stage outputs are combinational from state and inputs. No added latency.
//  - Priority in ST_RUN, highest first: excp_mem > D-wait > divide > I-wait > hazard_stall > branch.
//  - excp_mem: IDFlush=EXFlush=MEMFlush=1, pcWriteEn=1. From ST_DIV_WAIT, abort the divide and go to ST_RUN.
//    In ST_IMEM_WAIT, same flushes and set fetch_discard.
//  - D-wait (dcache_req_mem & !dcache_ready): hold PC/ID/EX/MEM (WriteEn=0), WBFlush=1, go to ST_DMEM_WAIT.
//    Stay until dcache_ready. The ready cycle releases all enables and returns to ST_RUN.
//    excp_mem never asserts in ST_DMEM_WAIT (bench asserts this).
//  - Divide: on div_start_ex, load counter with DIV_CYCLES-1 and go to ST_DIV_WAIT.
//    Hold PC/ID/EX; MEMFlush=1 every wait cycle.
//    At counter==0: div_done=1, enables released the same cycle, go to ST_RUN.
//    D-wait arriving during ST_DIV_WAIT is held off; the MEM bubble means it cannot arise.
//  - I-wait (icache_req & !icache_ready): pcWriteEn=0, IDFlush=1, go to ST_IMEM_WAIT.
//    Downstream stages continue.
//    Ready cycle: pcWriteEn=1. If fetch_discard is set, IDFlush=1 and clear fetch_discard.
//  - hazard_stall: pcWriteEn=0, IDWriteEn=0, EXFlush=1.
//  - Branch (pcsel==PC_BRANCH): IDFlush=1 only when ID is not held this cycle.
//    A stalled branch is re-evaluated next cycle. In ST_IMEM_WAIT a branch sets fetch_discard.
//  - Wait counter: increments in ST_DMEM_WAIT/ST_IMEM_WAIT, clears on exit.
//    Reaching MEM_TIMEOUT sets mem_timeout (sticky until reset); the FSM keeps waiting.
//  - Counters saturate and never wrap.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined: PERF_W-bit saturating counters of hazard, div, imem and dmem stall
//    cycles, on outputs perf_{hazard,div,imem,dmem}_cnt. Reset to 0.
//  STALL_PERF_CNT_EN undefined: no counters and no perf ports.
// STRUCTURE
//  cpuDefine gains typedef enum StallState {ST_RUN, ST_DIV_WAIT, ST_DMEM_WAIT, ST_IMEM_WAIT}.
//  Reuses PcSel/PC_BRANCH. One sub-module: stall_perf_cnt (one saturating counter, instanced x4).
// TESTING
//  1. hazard_stall=1 for 1 cycle -> pcWriteEn=IDWriteEn=0, EXFlush=1 that cycle only.
//  2. div_start_ex, DIV_CYCLES=33 -> PC/ID/EX held 33 cycles, MEMFlush=1 each,
//     div_done pulses in cycle 33.
//  3. dcache_req_mem with ready after 5 cycles -> 5 hold cycles with WBFlush=1,
//     release on the ready cycle.
//  4. excp_mem at divide cycle 10 -> flush ID/EX/MEM, div_done never pulses, back to ST_RUN next cycle.
//  5. PC_BRANCH during I-wait, ready after 3 cycles -> IDFlush=1 on the ready cycle, fetch_discard cleared.
//  6. dcache_ready withheld 255 cycles -> mem_timeout=1 and stays 1; rstn low mid-wait -> all state cleared.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: next-PC select codes,
// stall FSM states and a counter-width helper.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR} PcSel;

    typedef enum logic [1:0] {ST_RUN, ST_DIV_WAIT, ST_DMEM_WAIT, ST_IMEM_WAIT} StallState;

    // Bits needed to hold values 0..maxVal (never less than one bit).
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating stall-cycle counter used by pipe_stall_ctrl; the module only exists
// when STALL_PERF_CNT_EN is defined.
`ifdef STALL_PERF_CNT_EN
module stall_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch, divide,
// I/D-cache wait and MEM exception into stage enables/flushes. STALL_PERF_CNT_EN adds stall counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES  = 33,
    parameter int MEM_TIMEOUT = 255
`ifdef STALL_PERF_CNT_EN
    ,
    parameter int PERF_W      = 32
`endif
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      hazard_stall,
    input  PcSel      pcsel,
    input  logic      div_start_ex,
    input  logic      icache_req,
    input  logic      icache_ready,
    input  logic      dcache_req_mem,
    input  logic      dcache_ready,
    input  logic      excp_mem,
    output logic      pcWriteEn,
    output logic      IDWriteEn,
    output logic      EXWriteEn,
    output logic      MEMWriteEn,
    output logic      IDFlush,
    output logic      EXFlush,
    output logic      MEMFlush,
    output logic      WBFlush,
    output logic      div_done,
    output logic      mem_timeout,
    output StallState stall_state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_hazard_cnt,
    output logic [PERF_W-1:0] perf_div_cnt,
    output logic [PERF_W-1:0] perf_imem_cnt,
    output logic [PERF_W-1:0] perf_dmem_cnt
`endif
);

    localparam int DIV_W  = cntWidth(DIV_CYCLES - 1);
    localparam int WAIT_W = cntWidth(MEM_TIMEOUT);
    localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(DIV_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(MEM_TIMEOUT - 1);

    StallState         r_state;
    StallState         w_next;
    logic [DIV_W-1:0]  r_divCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_fetchDiscard;
    logic              r_memTimeout;
    logic              w_dWait;
    logic              w_iWait;
    logic              w_branch;
    logic              w_divLoad;
    logic              w_discardSet;
    logic              w_discardClr;

    assign w_dWait  = dcache_req_mem & ~dcache_ready;
    assign w_iWait  = icache_req & ~icache_ready;
    assign w_branch = (pcsel == PC_BRANCH);

    always_comb begin
        w_next       = r_state;
        pcWriteEn    = 1'b1;
        IDWriteEn    = 1'b1;
        EXWriteEn    = 1'b1;
        MEMWriteEn   = 1'b1;
        IDFlush      = 1'b0;
        EXFlush      = 1'b0;
        MEMFlush     = 1'b0;
        WBFlush      = 1'b0;
        div_done     = 1'b0;
        w_divLoad    = 1'b0;
        w_discardSet = 1'b0;
        w_discardClr = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (excp_mem) begin
                    IDFlush  = 1'b1;
                    EXFlush  = 1'b1;
                    MEMFlush = 1'b1;
                end else if (w_dWait) begin
                    pcWriteEn  = 1'b0;
                    IDWriteEn  = 1'b0;
                    EXWriteEn  = 1'b0;
                    MEMWriteEn = 1'b0;
                    WBFlush    = 1'b1;
                    w_next     = ST_DMEM_WAIT;
                end else if (div_start_ex) begin
                    pcWriteEn = 1'b0;
                    IDWriteEn = 1'b0;
                    EXWriteEn = 1'b0;
                    MEMFlush  = 1'b1;
                    w_divLoad = 1'b1;
                    w_next    = ST_DIV_WAIT;
                end else if (w_iWait) begin
                    pcWriteEn = 1'b0;
                    IDFlush   = 1'b1;
                    w_next    = ST_IMEM_WAIT;
                end else if (hazard_stall) begin
                    pcWriteEn = 1'b0;
                    IDWriteEn = 1'b0;
                    EXFlush   = 1'b1;
                end else if (w_branch) begin
                    IDFlush = 1'b1;
                end
            end
            ST_DIV_WAIT: begin
                if (excp_mem) begin
                    IDFlush  = 1'b1;
                    EXFlush  = 1'b1;
                    MEMFlush = 1'b1;
                    w_next   = ST_RUN;
                end else if (r_divCnt == '0) begin
                    div_done = 1'b1;
                    w_next   = ST_RUN;
                end else begin
                    pcWriteEn = 1'b0;
                    IDWriteEn = 1'b0;
                    EXWriteEn = 1'b0;
                    MEMFlush  = 1'b1;
                end
            end
            ST_DMEM_WAIT: begin
                if (dcache_ready) begin
                    w_next = ST_RUN;
                end else begin
                    pcWriteEn  = 1'b0;
                    IDWriteEn  = 1'b0;
                    EXWriteEn  = 1'b0;
                    MEMWriteEn = 1'b0;
                    WBFlush    = 1'b1;
                end
            end
            ST_IMEM_WAIT: begin
                // A redirect while the fetch is in flight marks its data stale.
                if (excp_mem) begin
                    IDFlush  = 1'b1;
                    EXFlush  = 1'b1;
                    MEMFlush = 1'b1;
                    if (icache_ready) begin
                        w_discardClr = 1'b1;
                        w_next       = ST_RUN;
                    end else begin
                        w_discardSet = 1'b1;
                    end
                end else if (w_dWait) begin
                    pcWriteEn  = 1'b0;
                    IDWriteEn  = 1'b0;
                    EXWriteEn  = 1'b0;
                    MEMWriteEn = 1'b0;
                    WBFlush    = 1'b1;
                end else if (icache_ready) begin
                    IDFlush      = r_fetchDiscard | w_branch;
                    w_discardClr = 1'b1;
                    w_next       = ST_RUN;
                end else begin
                    pcWriteEn = 1'b0;
                    IDFlush   = 1'b1;
                    if (w_branch) begin
                        w_discardSet = 1'b1;
                    end
                end
            end
        endcase
        if (!rstn) begin
            pcWriteEn  = 1'b0;
            IDWriteEn  = 1'b0;
            EXWriteEn  = 1'b0;
            MEMWriteEn = 1'b0;
            IDFlush    = 1'b1;
            EXFlush    = 1'b1;
            MEMFlush   = 1'b1;
            WBFlush    = 1'b1;
            div_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_RUN;
            r_divCnt       <= '0;
            r_waitCnt      <= '0;
            r_fetchDiscard <= 1'b0;
            r_memTimeout   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_divLoad) begin
                r_divCnt <= DIV_LOAD;
            end else if (w_next != ST_DIV_WAIT) begin
                r_divCnt <= '0;
            end else if (r_divCnt != '0) begin
                r_divCnt <= r_divCnt - DIV_W'(1);
            end
            // The timeout flag only reports; the FSM keeps waiting for the response.
            if (((r_state == ST_DMEM_WAIT) || (r_state == ST_IMEM_WAIT)) && (w_next == r_state)) begin
                if (r_waitCnt != WAIT_MAX) begin
                    r_waitCnt <= r_waitCnt + WAIT_W'(1);
                end
                if (r_waitCnt >= WAIT_PRE) begin
                    r_memTimeout <= 1'b1;
                end
            end else begin
                r_waitCnt <= '0;
            end
            if (w_discardClr) begin
                r_fetchDiscard <= 1'b0;
            end else if (w_discardSet) begin
                r_fetchDiscard <= 1'b1;
            end
        end
    end

    assign mem_timeout = r_memTimeout;
    assign stall_state = r_state;

`ifdef STALL_PERF_CNT_EN
    logic w_incHazard;
    logic w_incDiv;
    logic w_incImem;
    logic w_incDmem;

    // Each stall kind leaves a distinct enable/flush signature on the outputs.
    assign w_incHazard = (r_state == ST_RUN) & EXFlush & ~IDWriteEn;
    assign w_incDiv    = MEMFlush & ~EXWriteEn & MEMWriteEn;
    assign w_incImem   = ~pcWriteEn & IDFlush & IDWriteEn;
    assign w_incDmem   = WBFlush;

    stall_perf_cnt #(.W(PERF_W)) u_perfHazard (.clk(clk), .rstn(rstn), .i_inc(w_incHazard), .o_cnt(perf_hazard_cnt));
    stall_perf_cnt #(.W(PERF_W)) u_perfDiv    (.clk(clk), .rstn(rstn), .i_inc(w_incDiv),    .o_cnt(perf_div_cnt));
    stall_perf_cnt #(.W(PERF_W)) u_perfImem   (.clk(clk), .rstn(rstn), .i_inc(w_incImem),   .o_cnt(perf_imem_cnt));
    stall_perf_cnt #(.W(PERF_W)) u_perfDmem   (.clk(clk), .rstn(rstn), .i_inc(w_incDmem),   .o_cnt(perf_dmem_cnt));
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (default build, STALL_PERF_CNT_EN undefined).
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    // Output vector order: {pcWE, IDWE, EXWE, MEMWE, IDFl, EXFl, MEMFl, WBFl, div_done}
    localparam logic [8:0] O_RESET  = 9'b0000_1111_0;
    localparam logic [8:0] O_NORMAL = 9'b1111_0000_0;
    localparam logic [8:0] O_HAZARD = 9'b0011_0100_0;
    localparam logic [8:0] O_BRANCH = 9'b1111_1000_0;
    localparam logic [8:0] O_DIVHLD = 9'b0001_0010_0;
    localparam logic [8:0] O_DIVDN  = 9'b1111_0000_1;
    localparam logic [8:0] O_DHOLD  = 9'b0000_0001_0;
    localparam logic [8:0] O_EXCP   = 9'b1111_1110_0;
    localparam logic [8:0] O_IWAIT  = 9'b0111_1000_0;
    localparam logic [8:0] O_IRDYFL = 9'b1111_1000_0;

    logic      clk = 1'b0;
    logic      rstn;
    logic      hazard_stall, div_start_ex, icache_req, icache_ready;
    logic      dcache_req_mem, dcache_ready, excp_mem;
    PcSel      pcsel;
    logic      pcWriteEn, IDWriteEn, EXWriteEn, MEMWriteEn;
    logic      IDFlush, EXFlush, MEMFlush, WBFlush, div_done, mem_timeout;
    StallState stall_state;
    logic [8:0] obs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk(clk), .rstn(rstn), .hazard_stall(hazard_stall), .pcsel(pcsel),
        .div_start_ex(div_start_ex), .icache_req(icache_req), .icache_ready(icache_ready),
        .dcache_req_mem(dcache_req_mem), .dcache_ready(dcache_ready), .excp_mem(excp_mem),
        .pcWriteEn(pcWriteEn), .IDWriteEn(IDWriteEn), .EXWriteEn(EXWriteEn), .MEMWriteEn(MEMWriteEn),
        .IDFlush(IDFlush), .EXFlush(EXFlush), .MEMFlush(MEMFlush), .WBFlush(WBFlush),
        .div_done(div_done), .mem_timeout(mem_timeout), .stall_state(stall_state)
    );

    assign obs = {pcWriteEn, IDWriteEn, EXWriteEn, MEMWriteEn, IDFlush, EXFlush, MEMFlush, WBFlush, div_done};

    always @(negedge clk) begin
        if (rstn === 1'b1)
            assert (!((stall_state == ST_DMEM_WAIT) && (excp_mem === 1'b1)))
                else $error("[TB] excp_mem asserted during D-wait");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hazard_stall = 0; div_start_ex = 0; icache_req = 0; icache_ready = 0;
        dcache_req_mem = 0; dcache_ready = 0; excp_mem = 0; pcsel = PC_SEQ;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        checks++; if (obs !== O_RESET) begin errors++; $display("[TB] FAIL reset_outs got=%b exp=%b", obs, O_RESET); end
        checks++; if (stall_state !== ST_RUN) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=%0d", stall_state, ST_RUN); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got=%b exp=0", mem_timeout); end
        @(negedge clk) rstn = 1'b1;
        cyc();
        #1;
        checks++; if (obs !== O_NORMAL) begin errors++; $display("[TB] FAIL run_idle got=%b exp=%b", obs, O_NORMAL); end
    endtask

    task automatic test_hazard();
        hazard_stall = 1; #1;
        checks++; if (obs !== O_HAZARD) begin errors++; $display("[TB] FAIL hazard got=%b exp=%b", obs, O_HAZARD); end
        cyc(); hazard_stall = 0; #1;
        checks++; if (obs !== O_NORMAL) begin errors++; $display("[TB] FAIL hazard_release got=%b exp=%b", obs, O_NORMAL); end
    endtask

    task automatic test_branch();
        pcsel = PC_BRANCH; #1;
        checks++; if (obs !== O_BRANCH) begin errors++; $display("[TB] FAIL branch got=%b exp=%b", obs, O_BRANCH); end
        hazard_stall = 1; #1;
        checks++; if (obs !== O_HAZARD) begin errors++; $display("[TB] FAIL branch_held got=%b exp=%b", obs, O_HAZARD); end
        cyc(); hazard_stall = 0; #1;
        checks++; if (obs !== O_BRANCH) begin errors++; $display("[TB] FAIL branch_retry got=%b exp=%b", obs, O_BRANCH); end
        cyc(); pcsel = PC_SEQ;
    endtask

    task automatic test_divide();
        div_start_ex = 1; #1;
        checks++; if (obs !== O_DIVHLD) begin errors++; $display("[TB] FAIL div_start got=%b exp=%b", obs, O_DIVHLD); end
        for (int k = 1; k <= 32; k++) begin
            cyc(); div_start_ex = 0; #1;
            checks++; if (obs !== O_DIVHLD || stall_state !== ST_DIV_WAIT) begin
                errors++; $display("[TB] FAIL div_hold cyc=%0d got=%b/%0d exp=%b/%0d", k, obs, stall_state, O_DIVHLD, ST_DIV_WAIT);
            end
        end
        cyc(); #1;
        checks++; if (obs !== O_DIVDN) begin errors++; $display("[TB] FAIL div_done got=%b exp=%b", obs, O_DIVDN); end
        cyc(); #1;
        checks++; if (obs !== O_NORMAL || stall_state !== ST_RUN) begin
            errors++; $display("[TB] FAIL div_after got=%b/%0d exp=%b/%0d", obs, stall_state, O_NORMAL, ST_RUN);
        end
    endtask

    task automatic test_dcache();
        dcache_req_mem = 1; dcache_ready = 0; #1;
        checks++; if (obs !== O_DHOLD || stall_state !== ST_RUN) begin
            errors++; $display("[TB] FAIL dwait_enter got=%b/%0d exp=%b/%0d", obs, stall_state, O_DHOLD, ST_RUN);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            checks++; if (obs !== O_DHOLD || stall_state !== ST_DMEM_WAIT) begin
                errors++; $display("[TB] FAIL dwait_hold cyc=%0d got=%b/%0d exp=%b/%0d", k, obs, stall_state, O_DHOLD, ST_DMEM_WAIT);
            end
        end
        cyc(); dcache_ready = 1; #1;
        checks++; if (obs !== O_NORMAL) begin errors++; $display("[TB] FAIL dwait_release got=%b exp=%b", obs, O_NORMAL); end
        cyc(); idle(); #1;
        checks++; if (stall_state !== ST_RUN) begin errors++; $display("[TB] FAIL dwait_exit got=%0d exp=%0d", stall_state, ST_RUN); end
    endtask

    task automatic test_excp();
        bit seen;
        excp_mem = 1; hazard_stall = 1; #1;
        checks++; if (obs !== O_EXCP) begin errors++; $display("[TB] FAIL excp_run got=%b exp=%b", obs, O_EXCP); end
        cyc(); idle();
        div_start_ex = 1;
        for (int k = 1; k <= 10; k++) begin
            cyc(); div_start_ex = 0;
        end
        excp_mem = 1; #1;
        checks++; if (obs !== O_EXCP || stall_state !== ST_DIV_WAIT) begin
            errors++; $display("[TB] FAIL excp_div got=%b/%0d exp=%b/%0d", obs, stall_state, O_EXCP, ST_DIV_WAIT);
        end
        cyc(); excp_mem = 0; #1;
        checks++; if (obs !== O_NORMAL || stall_state !== ST_RUN) begin
            errors++; $display("[TB] FAIL excp_div_exit got=%b/%0d exp=%b/%0d", obs, stall_state, O_NORMAL, ST_RUN);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(); #1;
            if (div_done === 1'b1) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL excp_div_nodone got=%b exp=0", seen); end
    endtask

    task automatic test_imem_branch();
        icache_req = 1; icache_ready = 0; #1;
        checks++; if (obs !== O_IWAIT) begin errors++; $display("[TB] FAIL iwait_enter got=%b exp=%b", obs, O_IWAIT); end
        cyc(); pcsel = PC_BRANCH; #1;
        checks++; if (obs !== O_IWAIT || stall_state !== ST_IMEM_WAIT) begin
            errors++; $display("[TB] FAIL iwait_branch got=%b/%0d exp=%b/%0d", obs, stall_state, O_IWAIT, ST_IMEM_WAIT);
        end
        cyc(); pcsel = PC_SEQ; #1;
        checks++; if (obs !== O_IWAIT) begin errors++; $display("[TB] FAIL iwait_hold got=%b exp=%b", obs, O_IWAIT); end
        cyc(); icache_ready = 1; #1;
        checks++; if (obs !== O_IRDYFL) begin errors++; $display("[TB] FAIL iwait_discard got=%b exp=%b", obs, O_IRDYFL); end
        cyc(); icache_ready = 0; #1;
        checks++; if (obs !== O_IWAIT || stall_state !== ST_RUN) begin
            errors++; $display("[TB] FAIL iwait_reenter got=%b/%0d exp=%b/%0d", obs, stall_state, O_IWAIT, ST_RUN);
        end
        cyc(); icache_ready = 1; #1;
        checks++; if (obs !== O_NORMAL) begin errors++; $display("[TB] FAIL iwait_cleared got=%b exp=%b", obs, O_NORMAL); end
        cyc(); icache_ready = 0;
        cyc(); excp_mem = 1; #1;
        checks++; if (obs !== O_EXCP) begin errors++; $display("[TB] FAIL iwait_excp got=%b exp=%b", obs, O_EXCP); end
        cyc(); excp_mem = 0; icache_ready = 1; #1;
        checks++; if (obs !== O_IRDYFL) begin errors++; $display("[TB] FAIL iwait_excp_discard got=%b exp=%b", obs, O_IRDYFL); end
        cyc(); idle(); #1;
        checks++; if (obs !== O_NORMAL || stall_state !== ST_RUN) begin
            errors++; $display("[TB] FAIL iwait_exit got=%b/%0d exp=%b/%0d", obs, stall_state, O_NORMAL, ST_RUN);
        end
    endtask

    task automatic test_timeout();
        dcache_req_mem = 1; dcache_ready = 0;
        for (int k = 0; k < 255; k++) cyc();
        #1;
        checks++; if (mem_timeout !== 1'b0 || stall_state !== ST_DMEM_WAIT) begin
            errors++; $display("[TB] FAIL timeout_early got=%b/%0d exp=0/%0d", mem_timeout, stall_state, ST_DMEM_WAIT);
        end
        cyc(); #1;
        checks++; if (mem_timeout !== 1'b1 || obs !== O_DHOLD || stall_state !== ST_DMEM_WAIT) begin
            errors++; $display("[TB] FAIL timeout_set got=%b/%b/%0d exp=1/%b/%0d", mem_timeout, obs, stall_state, O_DHOLD, ST_DMEM_WAIT);
        end
        repeat (10) cyc();
        dcache_ready = 1;
        cyc(); idle(); #1;
        checks++; if (mem_timeout !== 1'b1 || stall_state !== ST_RUN) begin
            errors++; $display("[TB] FAIL timeout_sticky got=%b/%0d exp=1/%0d", mem_timeout, stall_state, ST_RUN);
        end
        dcache_req_mem = 1;
        cyc(); cyc();
        rstn = 1'b0; #1;
        checks++; if (obs !== O_RESET || stall_state !== ST_RUN || mem_timeout !== 1'b0) begin
            errors++; $display("[TB] FAIL midwait_reset got=%b/%0d/%b exp=%b/%0d/0", obs, stall_state, mem_timeout, O_RESET, ST_RUN);
        end
        idle();
        @(negedge clk) rstn = 1'b1;
        cyc(); dcache_req_mem = 1;
        repeat (20) cyc();
        #1;
        checks++; if (mem_timeout !== 1'b0 || stall_state !== ST_DMEM_WAIT) begin
            errors++; $display("[TB] FAIL waitcnt_cleared got=%b/%0d exp=0/%0d", mem_timeout, stall_state, ST_DMEM_WAIT);
        end
        dcache_ready = 1;
        cyc(); idle();
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_branch();
        test_divide();
        test_dcache();
        test_excp();
        test_imem_branch();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
